// File: rtl/race_pkg.sv
// Shared race-state definitions. The state encoder, the physics engines and
// the frame scheduler all use these codes.
package race_pkg;

    localparam int RACE_STATE_W = 3;

    localparam logic [RACE_STATE_W-1:0] RACE_IDLE      = 3'd0;
    localparam logic [RACE_STATE_W-1:0] RACE_SETTING   = 3'd1;
    localparam logic [RACE_STATE_W-1:0] RACE_COUNTDOWN = 3'd3;
    localparam logic [RACE_STATE_W-1:0] RACE_RACING    = 3'd4;
    localparam logic [RACE_STATE_W-1:0] RACE_PAUSE     = 3'd5;
    localparam logic [RACE_STATE_W-1:0] RACE_FINISH    = 3'd6;

    // Frame scheduler FSM: waiting for a frame tick, or requesting updates.
    typedef enum logic {
        S_WAIT = 1'b0,
        S_REQ  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Physics frame tick divider. Counts 0..TICK_DIV-1 while run is high and
// flags the last count as tick; clear returns the count to 0; holds otherwise.
module frame_tick_gen #(
    parameter int TICK_DIV = 1666667
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    // Divider counter: cleared outside racing/pause, frozen when not running.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div_cnt <= '0;
        end else if (run) begin
            if (div_cnt == LAST_CNT) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
        end
    end

    assign tick = run && (div_cnt == LAST_CNT);

endmodule

// File: rtl/physics_frame_scheduler.sv
// Physics frame scheduler: on each frame tick, requests one update per car in
// round-robin order, rotating the start car every completed frame.
// Optional build macro: PHYS_SCHED_OVERRUN_EN compiles in the saturating
// counter of ticks dropped while a sweep is still running.
//
// Handshake: upd_req is registered and one-hot. A car's update is accepted in
// the cycle its upd_req bit and its upd_ack bit are both high while state is
// RACING; the request moves on in the next cycle. Ack bits for cars not being
// requested, and acks while req is low or the race is paused, are ignored.
module physics_frame_scheduler
    import race_pkg::*;
#(
    parameter int NUM_CARS = 2,
    parameter int TICK_DIV = 1666667
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RACE_STATE_W-1:0] state,
    output logic [NUM_CARS-1:0]     upd_req,
    input  logic [NUM_CARS-1:0]     upd_ack,
    output logic                    sweep_done,
    output logic [15:0]             frame_count,
    output logic [7:0]              overrun_cnt,
    output sched_state_t            dbg_state
);

    localparam int PTR_W = $clog2(NUM_CARS);
    localparam logic [PTR_W-1:0] LAST_CAR = PTR_W'(NUM_CARS - 1);

    sched_state_t fsm_q, fsm_d;
    logic [PTR_W-1:0] cur_q, cur_d;
    logic [PTR_W-1:0] served_q, served_d;
    logic [PTR_W-1:0] start_q, start_d;
    logic [NUM_CARS-1:0] req_d;
    logic racing, paused, clear, tick, ack_hit, frame_end;

    assign racing    = (state == RACE_RACING);
    assign paused    = (state == RACE_PAUSE);
    assign clear     = !racing && !paused;
    assign ack_hit   = racing && (fsm_q == S_REQ) && (|(upd_req & upd_ack));
    assign dbg_state = fsm_q;

    frame_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .run   (racing),
        .clear (clear),
        .tick  (tick)
    );

    // Next-state logic: pause freezes everything, non-racing states abort.
    always_comb begin
        fsm_d     = fsm_q;
        cur_d     = cur_q;
        served_d  = served_q;
        start_d   = start_q;
        frame_end = 1'b0;
        if (clear) begin
            fsm_d    = S_WAIT;
            cur_d    = '0;
            served_d = '0;
            start_d  = '0;
        end else if (racing) begin
            case (fsm_q)
                S_WAIT: begin
                    if (tick) begin
                        fsm_d    = S_REQ;
                        cur_d    = start_q;
                        served_d = '0;
                    end
                end
                S_REQ: begin
                    if (ack_hit) begin
                        if (served_q == LAST_CAR) begin
                            fsm_d     = S_WAIT;
                            frame_end = 1'b1;
                            start_d   = (start_q == LAST_CAR) ? '0 : start_q + PTR_W'(1);
                        end else begin
                            cur_d    = (cur_q == LAST_CAR) ? '0 : cur_q + PTR_W'(1);
                            served_d = served_q + PTR_W'(1);
                        end
                    end
                end
                default: fsm_d = S_WAIT;
            endcase
        end
        req_d = '0;
        if (racing && (fsm_d == S_REQ)) begin
            req_d = NUM_CARS'(1) << cur_d;
        end
    end

    // FSM, pointers and registered request / done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= S_WAIT;
            cur_q      <= '0;
            served_q   <= '0;
            start_q    <= '0;
            upd_req    <= '0;
            sweep_done <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            cur_q      <= cur_d;
            served_q   <= served_d;
            start_q    <= start_d;
            upd_req    <= req_d;
            sweep_done <= frame_end;
        end
    end

    // Completed-sweep counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
        end else if (frame_end) begin
            frame_count <= frame_count + 16'd1;
        end
    end

`ifdef PHYS_SCHED_OVERRUN_EN
    // A tick arriving mid-sweep is dropped and counted, saturating at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_cnt <= '0;
        end else if (tick && (fsm_q == S_REQ) && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`else
    assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_physics_frame_scheduler.sv
// Bench for physics_frame_scheduler: directed scenarios with literal checks,
// plus a queue-based reference model compared on every falling clock edge.
module tb_physics_frame_scheduler;
    import race_pkg::*;

    localparam int NUM_CARS = 2;
    localparam int TICK_DIV = 4;
`ifdef PHYS_SCHED_OVERRUN_EN
    localparam int  EXP_OVR = 2;
    localparam bit  OVR_EN  = 1'b1;
`else
    localparam int  EXP_OVR = 0;
    localparam bit  OVR_EN  = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [RACE_STATE_W-1:0] state = RACE_IDLE;
    logic [NUM_CARS-1:0] upd_ack = '0;
    logic [NUM_CARS-1:0] upd_req;
    logic sweep_done;
    logic [15:0] frame_count;
    logic [7:0] overrun_cnt;
    sched_state_t dbg_state;

    always #5 clk = ~clk;

    physics_frame_scheduler #(
        .NUM_CARS (NUM_CARS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .upd_req     (upd_req),
        .upd_ack     (upd_ack),
        .sweep_done  (sweep_done),
        .frame_count (frame_count),
        .overrun_cnt (overrun_cnt),
        .dbg_state   (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // exp_q holds the cars still owed an update in the current frame, in order.
    logic [2:0] exp_q[$];
    int m_phase = 0;
    int m_start = 0;
    logic [NUM_CARS-1:0] m_req = '0;
    logic m_done = 1'b0;
    logic [15:0] m_fc = '0;
    logic [7:0] m_ovr = '0;
    bit model_on = 1'b0;

    task automatic model_step();
        bit racing;
        bit accepted;
        bit tk;
        bit busy;
        racing   = (state == RACE_RACING);
        accepted = racing && ((m_req & upd_ack) != '0);
        tk       = racing && (m_phase == TICK_DIV - 1);
        busy     = (exp_q.size() != 0);
        m_done   = 1'b0;
        if (racing) begin
            m_phase = (m_phase + 1) % TICK_DIV;
            if (accepted) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    m_done  = 1'b1;
                    m_fc    = m_fc + 16'd1;
                    m_start = (m_start + 1) % NUM_CARS;
                end
            end
            if (tk) begin
                if (busy) begin
                    if (OVR_EN && m_ovr != 8'hFF) m_ovr = m_ovr + 8'd1;
                end else begin
                    for (int i = 0; i < NUM_CARS; i++) exp_q.push_back(3'((m_start + i) % NUM_CARS));
                end
            end
            m_req = (exp_q.size() != 0) ? (NUM_CARS'(1) << exp_q[0]) : '0;
        end else if (state == RACE_PAUSE) begin
            m_req = '0;
        end else begin
            exp_q.delete();
            m_phase = 0;
            m_start = 0;
            m_req   = '0;
        end
    endtask

    // Compare process: check outputs, then advance the model on sampled inputs.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("model_upd_req", upd_req, m_req);
                check("model_sweep_done", sweep_done, m_done);
                check("model_frame_count", frame_count, m_fc);
                check("model_overrun_cnt", overrun_cnt, m_ovr);
            end
            if (rst) begin
                exp_q.delete();
                m_phase  = 0;
                m_start  = 0;
                m_req    = '0;
                m_done   = 1'b0;
                m_fc     = '0;
                m_ovr    = '0;
                model_on = 1'b1;
            end else if (model_on) begin
                model_step();
            end
        end
    end

    // ---------------- driver tasks ----------------
    int ack_log[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int car_of(input logic [NUM_CARS-1:0] req);
        for (int i = 0; i < NUM_CARS; i++) if (req[i]) return i;
        return -1;
    endfunction

    task automatic auto_ack();
        if (!rst && state == RACE_RACING && upd_req != '0) begin
            upd_ack = upd_req;
            ack_log.push_back(car_of(upd_req));
        end else begin
            upd_ack = '0;
        end
    endtask

    task automatic run_frames(input int n, input int budget);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            auto_ack();
            step();
            cyc++;
            if (sweep_done) got++;
        end
        check("run_frames_sweep_done_count", got, n);
    endtask

    task automatic wait_req(input logic [NUM_CARS-1:0] val, input int budget);
        int cyc = 0;
        while (upd_req !== val && cyc < budget) begin
            step();
            cyc++;
        end
        check("wait_req", upd_req, val);
    endtask

    // ---------------- directed scenarios ----------------
    int exp_order[6] = '{0, 1, 1, 0, 0, 1};

    initial begin
        int cyc;
        rst = 1'b1;
        state = RACE_IDLE;
        upd_ack = '0;
        repeat (3) step();
        check("reset_upd_req", upd_req, 0);
        check("reset_sweep_done", sweep_done, 0);
        check("reset_frame_count", frame_count, 0);
        check("reset_overrun_cnt", overrun_cnt, 0);
        check("reset_dbg_state", dbg_state, S_WAIT);

        // Normal frames: start car rotates 0,1,0.
        rst = 1'b0;
        state = RACE_RACING;
        run_frames(3, 60);
        check("order_len", ack_log.size(), 6);
        for (int i = 0; i < 6 && i < ack_log.size(); i++) check("order_car", ack_log[i], exp_order[i]);
        check("normal_frame_count", frame_count, 3);
        check("normal_overrun_cnt", overrun_cnt, 0);

        // Pause while car1 is requested; acks held high must be ignored.
        upd_ack = '0;
        wait_req(2'b10, 20);
        state = RACE_PAUSE;
        upd_ack = 2'b11;
        repeat (5) begin
            step();
            check("pause_upd_req", upd_req, 0);
            check("pause_frame_count", frame_count, 3);
        end
        state = RACE_RACING;
        upd_ack = '0;
        step();
        check("resume_upd_req", upd_req, 2'b10);
        run_frames(1, 20);
        check("resume_frame_count", frame_count, 4);

        // Overrun: car0 unanswered for 10 cycles spans two ticks.
        upd_ack = '0;
        wait_req(2'b01, 20);
        for (int i = 0; i < 10; i++) begin
            check("overrun_upd_req", upd_req, 2'b01);
            if (i < 9) step();
        end
        check("overrun_cnt_after_hold", overrun_cnt, EXP_OVR);
        check("overrun_frame_count", frame_count, 4);

        // Spurious ack on a non-requested car.
        step();
        upd_ack = 2'b10;
        step();
        check("spurious_upd_req", upd_req, 2'b01);
        check("spurious_sweep_done", sweep_done, 0);
        upd_ack = 2'b01;
        step();
        check("advance_upd_req", upd_req, 2'b10);

        // Abort mid-sweep with FINISH.
        state = RACE_FINISH;
        upd_ack = '0;
        step();
        check("abort_upd_req", upd_req, 0);
        check("abort_frame_count", frame_count, 4);

        // Return to racing: divider restarted, car0 requested in the 5th cycle.
        state = RACE_RACING;
        repeat (3) begin
            step();
            check("restart_idle_req", upd_req, 0);
        end
        step();
        check("restart_car0", upd_req, 2'b01);
        run_frames(1, 20);
        check("restart_frame_count", frame_count, 5);

        // Wrap: preload 0xFFFF, one more frame wraps to 0.
        force dut.frame_count = 16'hFFFF;
        m_fc = 16'hFFFF;
        upd_ack = '0;
        step();
        release dut.frame_count;
        check("preload_frame_count", frame_count, 16'hFFFF);
        run_frames(1, 40);
        check("wrap_frame_count", frame_count, 0);
        run_frames(1, 40);
        check("post_wrap_frame_count", frame_count, 1);

        // Reset mid-sweep clears every output on the next cycle.
        upd_ack = '0;
        cyc = 0;
        while (upd_req == '0 && cyc < 20) begin
            step();
            cyc++;
        end
        check("pre_reset_req_active", (upd_req != '0), 1);
        rst = 1'b1;
        step();
        check("rst_upd_req", upd_req, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_overrun_cnt", overrun_cnt, 0);
        rst = 1'b0;
        state = RACE_IDLE;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/physics_frame_scheduler.md
# physics_frame_scheduler

Frame-rate scheduler for the per-car physics engines. It divides `clk` into a fixed physics frame tick and, on each tick, sequences one update request per car in round-robin order over a req/ack handshake. It sits between the global race state encoder and the bank of physics engines, gating all physics updates to the RACING state.

## Interface

**Parameters**
- `NUM_CARS`, default 2: number of physics engines served (2..8).
- `TICK_DIV`, default 1666667: clk cycles per physics frame (100 MHz / 60). Minimum 4.

**Ports**
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `state`  in  3: race state code (IDLE=0, SETTING=1, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6).
- `upd_req`  out  NUM_CARS: one-hot update request; at most one bit high.
- `upd_ack`  in  NUM_CARS: per-car acknowledge; sampled only on the bit whose req is high.
- `sweep_done`  out  1: one-cycle pulse after the last car of a frame is acked.
- `frame_count`  out  16: completed sweeps, wraps 0xFFFF→0.
- `overrun_cnt`  out  8: dropped ticks, saturating.

## Operation

- Tick divider `div_cnt` counts 0..TICK_DIV-1 while state==RACING. `tick` is asserted in the cycle `div_cnt`==TICK_DIV-1, then the counter wraps to 0.
- FSM states:
  - S_WAIT: no req. On `tick`, go to S_REQ with `cur`=`start_ptr` and `served`=0.
  - S_REQ: `upd_req[cur]`=1. On `upd_ack[cur]`:
    - If `served`==NUM_CARS-1, go to S_WAIT. Pulse `sweep_done`, increment `frame_count`, and set `start_ptr`=(`start_ptr`+1) mod NUM_CARS.
    - Otherwise set `cur`=(`cur`+1) mod NUM_CARS and increment `served`.
- Round-robin start rotates every completed frame for fairness.
- Overrun: if `tick` occurs while in S_REQ, the tick is dropped, not queued, and `overrun_cnt` increments, saturating at 255.
- PAUSE:
  - `div_cnt`, FSM state, `cur`, `served` and `start_ptr` are frozen, and `upd_req` is forced to 0.
  - Acks are ignored.
  - On return to RACING, the held req reasserts in the next cycle.
- Any other state (IDLE, SETTING, COUNTDOWN, FINISH, undefined codes):
  - Sweep aborted; FSM goes to S_WAIT.
  - `div_cnt`, `cur`, `served` and `start_ptr` are cleared to 0.
  - `frame_count` and `overrun_cnt` hold.
- Acks on non-requested bits, or while req is low, have no effect.

## Timing

- Reset values: `upd_req`=0, `sweep_done`=0, `frame_count`=0, `overrun_cnt`=0. Internal state: FSM=S_WAIT, `div_cnt`=0, `start_ptr`=0.
- Reset mid-sweep aborts immediately. `rst` has priority over `state`.
- All outputs are registered.
- `tick` in cycle N → `upd_req` high in cycle N+1.
- Ack sampled high in cycle K:
  - In cycle K+1, req moves to the next car with no idle gap, or drops to 0 for the last car.
  - `sweep_done` is high in cycle K+1 only, and `frame_count` updates in cycle K+1.
- Minimum sweep: NUM_CARS cycles when every ack is returned combinationally.
- State change takes effect on the cycle it is sampled. Req drops in the following cycle.

## Configuration

- `PHYS_SCHED_OVERRUN_EN`:
  - Defined: overrun detection and the saturating `overrun_cnt` are compiled in.
  - Undefined: no overrun logic; `overrun_cnt` is tied to 0 and ticks during S_REQ are silently dropped.
- Sweep behaviour is identical in both builds.

## Structure

- Shared package `race_pkg` holds the 3-bit state code constants and the `RACE_STATE_W`=3 width constant. The state encoder and physics engines use the same package.
- Sub-module `frame_tick_gen` (params `TICK_DIV`; ports `clk`, `rst`, `run`, `clear`, `tick`) implements the divider.
- The top holds the FSM, the round-robin pointers and the counters.

## Test plan

Bench settings: TICK_DIV=4, NUM_CARS=2, acks returned one cycle after req unless stated.

- **Normal frames:** rst, then state=RACING, run 3 frames. Expected:
  - Req order per frame: car0,car1 / car1,car0 / car0,car1.
  - `sweep_done` pulses three times, `frame_count`=3, `overrun_cnt`=0.
- **Overrun:** hold `upd_ack`=0 for 10 cycles in RACING. Expected:
  - `upd_req` stays 0b01.
  - `overrun_cnt`=2 with the macro defined, 0 without.
  - `frame_count` unchanged.
- **Pause mid-sweep:** state=PAUSE while `upd_req`=0b10, hold 5 cycles with ack=1. Expected:
  - `upd_req`=0 throughout; no progress.
  - State back to RACING → `upd_req`=0b10 next cycle, and the sweep completes normally.
- **Abort:** state=FINISH mid-sweep. Expected:
  - `upd_req`=0 next cycle.
  - Return to RACING → first req is car0 exactly 5 cycles later (`div_cnt` restarted).
  - `frame_count` held.
- **Spurious ack:** drive `upd_ack`=0b10 while `upd_req`=0b01 → no advance, no `sweep_done`.
- **Wrap and reset:** preload to `frame_count`=0xFFFF (force), complete one frame → 0x0000. Assert rst mid-sweep → all outputs 0 the next cycle.
